// File: rtl/id_ex_stage_if.sv
// Signal bundle between the decode stage, the ID/EX register and the ALU/hazard logic.
// The master side drives ID/MEM/WB inputs; the slave side is the ID/EX stage itself.
interface id_ex_stage_if #(
    parameter int WIDTH = 32,
    parameter int RBITS = 5
);
    logic             stall;
    logic             flush;

    logic             d_valid;
    logic [WIDTH-1:0] d_rd1;
    logic [WIDTH-1:0] d_rd2;
    logic [WIDTH-1:0] d_signimm;
    logic [RBITS-1:0] d_rs;
    logic [RBITS-1:0] d_rt;
    logic [RBITS-1:0] d_rd;
    logic [2:0]       d_alucontrol;
    logic             d_alusrc;
    logic             d_regdst;
    logic             d_regwrite;
    logic             d_memtoreg;
    logic             d_memwrite;

    logic             m_regwrite;
    logic [RBITS-1:0] m_writereg;
    logic [WIDTH-1:0] m_aluout;
    logic             w_regwrite;
    logic [RBITS-1:0] w_writereg;
    logic [WIDTH-1:0] w_result;

    logic             e_valid;
    logic [WIDTH-1:0] e_srca;
    logic [WIDTH-1:0] e_srcb;
    logic [2:0]       e_alucontrol;
    logic [WIDTH-1:0] e_writedata;
    logic [RBITS-1:0] e_writereg;
    logic [RBITS-1:0] e_rs;
    logic [RBITS-1:0] e_rt;
    logic             e_regwrite;
    logic             e_memtoreg;
    logic             e_memwrite;

    modport master (
        output stall, flush,
        output d_valid, d_rd1, d_rd2, d_signimm, d_rs, d_rt, d_rd,
        output d_alucontrol, d_alusrc, d_regdst, d_regwrite, d_memtoreg, d_memwrite,
        output m_regwrite, m_writereg, m_aluout, w_regwrite, w_writereg, w_result,
        input  e_valid, e_srca, e_srcb, e_alucontrol, e_writedata, e_writereg,
        input  e_rs, e_rt, e_regwrite, e_memtoreg, e_memwrite
    );

    modport slave (
        input  stall, flush,
        input  d_valid, d_rd1, d_rd2, d_signimm, d_rs, d_rt, d_rd,
        input  d_alucontrol, d_alusrc, d_regdst, d_regwrite, d_memtoreg, d_memwrite,
        input  m_regwrite, m_writereg, m_aluout, w_regwrite, w_writereg, w_result,
        output e_valid, e_srca, e_srcb, e_alucontrol, e_writedata, e_writereg,
        output e_rs, e_rt, e_regwrite, e_memtoreg, e_memwrite
    );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with MEM/WB operand forwarding into the ALU.
// Stall holds the stage but keeps refreshing the operand registers with forwarded values.
module id_ex_stage #(
    parameter int WIDTH = 32,
    parameter int RBITS = 5
) (
    input  logic          clk,
    input  logic          reset,
    id_ex_stage_if.slave  io
);

    logic             valid_q,    valid_d;
    logic [WIDTH-1:0] rd1_q,      rd1_d;
    logic [WIDTH-1:0] rd2_q,      rd2_d;
    logic [WIDTH-1:0] signimm_q,  signimm_d;
    logic [RBITS-1:0] rs_q,       rs_d;
    logic [RBITS-1:0] rt_q,       rt_d;
    logic [RBITS-1:0] writereg_q, writereg_d;
    logic [2:0]       alucontrol_q, alucontrol_d;
    logic             alusrc_q,   alusrc_d;
    logic             regwrite_q, regwrite_d;
    logic             memtoreg_q, memtoreg_d;
    logic             memwrite_q, memwrite_d;

    logic [WIDTH-1:0] fwd_a;
    logic [WIDTH-1:0] fwd_b;

    // MEM result is younger than WB, so it wins; register 0 is never bypassed.
    function automatic logic [WIDTH-1:0] bypass(
        input logic [RBITS-1:0] src,
        input logic [WIDTH-1:0] regval,
        input logic             m_we,
        input logic [RBITS-1:0] m_dst,
        input logic [WIDTH-1:0] m_val,
        input logic             w_we,
        input logic [RBITS-1:0] w_dst,
        input logic [WIDTH-1:0] w_val
    );
        logic [WIDTH-1:0] res;
        res = regval;
        if (src != '0 && m_we && m_dst == src)
            res = m_val;
        else if (src != '0 && w_we && w_dst == src)
            res = w_val;
        return res;
    endfunction

    always_comb begin
        fwd_a = bypass(rs_q, rd1_q, io.m_regwrite, io.m_writereg, io.m_aluout,
                       io.w_regwrite, io.w_writereg, io.w_result);
        fwd_b = bypass(rt_q, rd2_q, io.m_regwrite, io.m_writereg, io.m_aluout,
                       io.w_regwrite, io.w_writereg, io.w_result);
    end

    always_comb begin
        valid_d      = valid_q;
        rd1_d        = rd1_q;
        rd2_d        = rd2_q;
        signimm_d    = signimm_q;
        rs_d         = rs_q;
        rt_d         = rt_q;
        writereg_d   = writereg_q;
        alucontrol_d = alucontrol_q;
        alusrc_d     = alusrc_q;
        regwrite_d   = regwrite_q;
        memtoreg_d   = memtoreg_q;
        memwrite_d   = memwrite_q;

        if (io.flush || (!io.stall && !io.d_valid)) begin
            valid_d      = 1'b0;
            rd1_d        = '0;
            rd2_d        = '0;
            signimm_d    = '0;
            rs_d         = '0;
            rt_d         = '0;
            writereg_d   = '0;
            alucontrol_d = '0;
            alusrc_d     = 1'b0;
            regwrite_d   = 1'b0;
            memtoreg_d   = 1'b0;
            memwrite_d   = 1'b0;
        end else if (io.stall) begin
            // Capture the bypassed value so it outlives the producer retiring.
            rd1_d = fwd_a;
            rd2_d = fwd_b;
        end else begin
            valid_d      = 1'b1;
            rd1_d        = io.d_rd1;
            rd2_d        = io.d_rd2;
            signimm_d    = io.d_signimm;
            rs_d         = io.d_rs;
            rt_d         = io.d_rt;
            writereg_d   = io.d_regdst ? io.d_rd : io.d_rt;
            alucontrol_d = io.d_alucontrol;
            alusrc_d     = io.d_alusrc;
            regwrite_d   = io.d_regwrite;
            memtoreg_d   = io.d_memtoreg;
            memwrite_d   = io.d_memwrite;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q      <= 1'b0;
            rd1_q        <= '0;
            rd2_q        <= '0;
            signimm_q    <= '0;
            rs_q         <= '0;
            rt_q         <= '0;
            writereg_q   <= '0;
            alucontrol_q <= '0;
            alusrc_q     <= 1'b0;
            regwrite_q   <= 1'b0;
            memtoreg_q   <= 1'b0;
            memwrite_q   <= 1'b0;
        end else begin
            valid_q      <= valid_d;
            rd1_q        <= rd1_d;
            rd2_q        <= rd2_d;
            signimm_q    <= signimm_d;
            rs_q         <= rs_d;
            rt_q         <= rt_d;
            writereg_q   <= writereg_d;
            alucontrol_q <= alucontrol_d;
            alusrc_q     <= alusrc_d;
            regwrite_q   <= regwrite_d;
            memtoreg_q   <= memtoreg_d;
            memwrite_q   <= memwrite_d;
        end
    end

    assign io.e_valid      = valid_q;
    assign io.e_srca       = fwd_a;
    assign io.e_writedata  = fwd_b;
    assign io.e_srcb       = alusrc_q ? signimm_q : fwd_b;
    assign io.e_alucontrol = alucontrol_q;
    assign io.e_writereg   = writereg_q;
    assign io.e_rs         = rs_q;
    assign io.e_rt         = rt_q;
    assign io.e_regwrite   = valid_q & regwrite_q;
    assign io.e_memtoreg   = valid_q & memtoreg_q;
    assign io.e_memwrite   = valid_q & memwrite_q;

endmodule
